// File: rtl/kf_fixed_pkg.sv
// ----------------------------------------------------------------------------
// kf_fixed_pkg
// Shared fixed-point definitions for the Kalman filter pipeline stages
// (output estimator, measurement update, covariance update).
//
// Contents:
//   KF_N / KF_FRAC   default word width and fractional bits (signed Q(N-FRAC).FRAC)
//   KF_ONE           1.0 in the default format
//   KF_ROUND         half an LSB of the integer part, used for round-half-up
//   KF_WIDE          width of the intermediate signed arithmetic used by sat_n
//   kf_state_e       serial-datapath FSM state encoding
//   sat_n / sat_hit  clamp a wide signed value to an n-bit signed range, and
//                    report whether that clamp was active
// ----------------------------------------------------------------------------
package kf_fixed_pkg;

    localparam int KF_N     = 20;
    localparam int KF_FRAC  = 10;
    localparam int KF_ONE   = 32'sd1 <<< KF_FRAC;
    localparam int KF_ROUND = 32'sd1 <<< (KF_FRAC - 1);
    localparam int KF_WIDE  = 64;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_M0   = 3'd1,
        ST_M1   = 3'd2,
        ST_M2   = 3'd3,
        ST_M3   = 3'd4,
        ST_WB   = 3'd5
    } kf_state_e;

    // Clamp v into [-(2^(n-1)), 2^(n-1)-1]; the caller narrows the result to n bits.
    function automatic logic signed [KF_WIDE-1:0] sat_n(
        input logic signed [KF_WIDE-1:0] v,
        input int unsigned               n
    );
        logic signed [KF_WIDE-1:0] hi;
        logic signed [KF_WIDE-1:0] lo;
        hi = (64'sd1 <<< (n - 32'd1)) - 64'sd1;
        lo = -(64'sd1 <<< (n - 32'd1));
        if (v > hi) begin
            sat_n = hi;
        end else if (v < lo) begin
            sat_n = lo;
        end else begin
            sat_n = v;
        end
    endfunction

    // 1 when sat_n(v, n) would have to clamp v.
    function automatic logic sat_hit(
        input logic signed [KF_WIDE-1:0] v,
        input int unsigned               n
    );
        logic signed [KF_WIDE-1:0] hi;
        logic signed [KF_WIDE-1:0] lo;
        hi = (64'sd1 <<< (n - 32'd1)) - 64'sd1;
        lo = -(64'sd1 <<< (n - 32'd1));
        if ((v > hi) || (v < lo)) begin
            sat_hit = 1'b1;
        end else begin
            sat_hit = 1'b0;
        end
    endfunction

endpackage

// File: rtl/kf_mac_serial.sv
// ----------------------------------------------------------------------------
// kf_mac_serial
// Signed N x N multiplier feeding a (2N+1)-bit accumulator. One product per
// enabled cycle; clr_i starts a new sum with the current product instead of
// adding to the previous one. Shared by the serial Kalman stages.
//
// Ports:
//   clk      in   1      clock, rising edge
//   rst_n    in   1      asynchronous active-low reset (accumulator to 0)
//   en_i     in   1      capture this cycle's product
//   clr_i    in   1      with en_i: acc = a*b, otherwise acc += a*b
//   a_i      in   N      signed multiplicand
//   b_i      in   N      signed multiplier
//   acc_o    out  2N+1   registered accumulator
// ----------------------------------------------------------------------------
module kf_mac_serial #(
    parameter int N = 20
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en_i,
    input  logic           clr_i,
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N:0]   acc_o
);

    logic signed [2*N-1:0] prod_s;
    logic        [2*N:0]   acc_d;
    logic        [2*N:0]   acc_q;

    // Full-precision product: both operands sign-extended to 2N bits first.
    always_comb begin
        prod_s = $signed({{N{a_i[N-1]}}, a_i}) * $signed({{N{b_i[N-1]}}, b_i});
    end

    // Accumulator next value; the extra top bit keeps the two-term sum from wrapping.
    always_comb begin
        acc_d = acc_q;
        if (en_i) begin
            if (clr_i) begin
                acc_d = {prod_s[2*N-1], prod_s};
            end else begin
                acc_d = $signed(acc_q) + $signed({prod_s[2*N-1], prod_s});
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/kf_state_update_serial.sv
// ----------------------------------------------------------------------------
// kf_state_update_serial
// Kalman measurement-update stage: y = sat(z - zh), X = sat(x + round(K*y)),
// all in signed Q(N-FRAC).FRAC, using one shared multiplier over four cycles
// (IDLE -> M0 -> M1 -> M2 -> M3 -> WB -> IDLE).
//
// Optional feature macro: KF_UPD_SAT_FLAG_EN adds the sat output, set with
// done when any innovation or final clamp saturated in that operation.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start                one-cycle request, sampled only in IDLE
//   z00, z10             measurement vector
//   zh00, zh10           predicted output H*x
//   k00, k01, k10, k11   gain matrix K, row-major
//   x00, x10             predicted state
//   busy                 high from the cycle after start is accepted until done
//   done                 one-cycle pulse, X00/X10 valid from this cycle
//   X00, X10             updated state, held until the next done
//   sat                  (KF_UPD_SAT_FLAG_EN only) saturation seen in the operation
// ----------------------------------------------------------------------------
module kf_state_update_serial
    import kf_fixed_pkg::*;
#(
    parameter int N    = KF_N,
    parameter int FRAC = KF_FRAC
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] z00,
    input  logic [N-1:0] z10,
    input  logic [N-1:0] zh00,
    input  logic [N-1:0] zh10,
    input  logic [N-1:0] k00,
    input  logic [N-1:0] k01,
    input  logic [N-1:0] k10,
    input  logic [N-1:0] k11,
    input  logic [N-1:0] x00,
    input  logic [N-1:0] x10,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] X00,
`ifdef KF_UPD_SAT_FLAG_EN
    output logic         sat,
`endif
    output logic [N-1:0] X10
);

    localparam int                        W2      = 2 * N + 1;
    localparam logic signed [KF_WIDE-1:0] ROUND_W = 64'sd1 <<< (FRAC - 1);

    kf_state_e     state_q;
    logic          busy_q;
    logic          done_q;
    logic [N-1:0]  upd00_q;
    logic [N-1:0]  upd10_q;

    // Operands latched when start is accepted.
    logic [N-1:0]  k00_q, k01_q, k10_q, k11_q;
    logic [N-1:0]  x00_q, x10_q;
    logic [N-1:0]  y0_q, y1_q;
    logic [W2-1:0] acc0_q;

    // Innovation and write-back next values.
    logic signed [KF_WIDE-1:0] diff0_s, diff1_s;
    logic [N-1:0]              y0_d, y1_d;
    logic                      y_sat_d;
    logic signed [KF_WIDE-1:0] sum0_s, sum1_s;
    logic [N-1:0]              upd00_d, upd10_d;
    logic                      fin_sat_d;

    // Shared MAC control.
    logic          mac_en_s;
    logic          mac_clr_s;
    logic [N-1:0]  mac_a_s;
    logic [N-1:0]  mac_b_s;
    logic [W2-1:0] mac_acc_s;

    // Innovation: the difference is formed at full width so nothing wraps before the clamp.
    always_comb begin
        diff0_s = $signed({{(KF_WIDE-N){z00[N-1]}}, z00}) - $signed({{(KF_WIDE-N){zh00[N-1]}}, zh00});
        diff1_s = $signed({{(KF_WIDE-N){z10[N-1]}}, z10}) - $signed({{(KF_WIDE-N){zh10[N-1]}}, zh10});
        y0_d    = N'(sat_n(diff0_s, N));
        y1_d    = N'(sat_n(diff1_s, N));
        y_sat_d = sat_hit(diff0_s, N) | sat_hit(diff1_s, N);
    end

    // Write-back: round half up (add half LSB, arithmetic shift = floor), add x, clamp.
    always_comb begin
        sum0_s    = $signed({{(KF_WIDE-N){x00_q[N-1]}}, x00_q})
                  + (($signed({{(KF_WIDE-W2){acc0_q[W2-1]}}, acc0_q}) + ROUND_W) >>> FRAC);
        sum1_s    = $signed({{(KF_WIDE-N){x10_q[N-1]}}, x10_q})
                  + (($signed({{(KF_WIDE-W2){mac_acc_s[W2-1]}}, mac_acc_s}) + ROUND_W) >>> FRAC);
        upd00_d   = N'(sat_n(sum0_s, N));
        upd10_d   = N'(sat_n(sum1_s, N));
        fin_sat_d = sat_hit(sum0_s, N) | sat_hit(sum1_s, N);
    end

    // Operand schedule for the single multiplier; M0/M2 start a fresh sum.
    always_comb begin
        mac_en_s  = 1'b0;
        mac_clr_s = 1'b0;
        mac_a_s   = '0;
        mac_b_s   = '0;
        case (state_q)
            ST_M0: begin
                mac_en_s  = 1'b1;
                mac_clr_s = 1'b1;
                mac_a_s   = k00_q;
                mac_b_s   = y0_q;
            end
            ST_M1: begin
                mac_en_s  = 1'b1;
                mac_clr_s = 1'b0;
                mac_a_s   = k01_q;
                mac_b_s   = y1_q;
            end
            ST_M2: begin
                mac_en_s  = 1'b1;
                mac_clr_s = 1'b1;
                mac_a_s   = k10_q;
                mac_b_s   = y0_q;
            end
            ST_M3: begin
                mac_en_s  = 1'b1;
                mac_clr_s = 1'b0;
                mac_a_s   = k11_q;
                mac_b_s   = y1_q;
            end
            default: begin
                mac_en_s  = 1'b0;
                mac_clr_s = 1'b0;
                mac_a_s   = '0;
                mac_b_s   = '0;
            end
        endcase
    end

    kf_mac_serial #(
        .N (N)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (mac_en_s),
        .clr_i (mac_clr_s),
        .a_i   (mac_a_s),
        .b_i   (mac_b_s),
        .acc_o (mac_acc_s)
    );

    // Control FSM with registered busy/done/result.
    // Row 0's sum sits in the MAC during M2 and is parked in acc0_q while row 1 starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            upd00_q <= '0;
            upd10_q <= '0;
            k00_q   <= '0;
            k01_q   <= '0;
            k10_q   <= '0;
            k11_q   <= '0;
            x00_q   <= '0;
            x10_q   <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            acc0_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        k00_q   <= k00;
                        k01_q   <= k01;
                        k10_q   <= k10;
                        k11_q   <= k11;
                        x00_q   <= x00;
                        x10_q   <= x10;
                        y0_q    <= y0_d;
                        y1_q    <= y1_d;
                        busy_q  <= 1'b1;
                        state_q <= ST_M0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_M0: state_q <= ST_M1;
                ST_M1: state_q <= ST_M2;
                ST_M2: begin
                    acc0_q  <= mac_acc_s;
                    state_q <= ST_M3;
                end
                ST_M3: state_q <= ST_WB;
                ST_WB: begin
                    upd00_q <= upd00_d;
                    upd10_q <= upd10_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef KF_UPD_SAT_FLAG_EN
    logic y_sat_q;
    logic sat_q;

    // Saturation flag: innovation clamp remembered at start, combined with final clamp at WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_sat_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && start) begin
                y_sat_q <= y_sat_d;
            end else if (state_q == ST_WB) begin
                sat_q <= y_sat_q | fin_sat_d;
            end else begin
                y_sat_q <= y_sat_q;
            end
        end
    end

    assign sat = sat_q;
`else
    logic unused_sat_s;

    // Without the flag port the clamp indications have no consumer.
    always_comb begin
        unused_sat_s = y_sat_d ^ fin_sat_d;
    end
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign X00  = upd00_q;
    assign X10  = upd10_q;

endmodule

// File: tb/tb_kf_state_update_serial.sv
// ----------------------------------------------------------------------------
// tb_kf_state_update_serial
// Directed bench for the serial Kalman measurement-update stage (N=20,
// FRAC=10, 1.0 = 1024). Expected values are hand-computed constants.
// Honours KF_UPD_SAT_FLAG_EN for the optional sat output.
// ----------------------------------------------------------------------------
module tb_kf_state_update_serial;

    localparam int N = 20;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] z00, z10, zh00, zh10;
    logic [N-1:0] k00, k01, k10, k11;
    logic [N-1:0] x00, x10;
    logic         busy;
    logic         done;
    logic [N-1:0] X00, X10;
`ifdef KF_UPD_SAT_FLAG_EN
    logic         sat;
`endif

    int errors = 0;
    int checks = 0;

    kf_state_update_serial #(.N(20), .FRAC(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .z00   (z00),
        .z10   (z10),
        .zh00  (zh00),
        .zh10  (zh10),
        .k00   (k00),
        .k01   (k01),
        .k10   (k10),
        .k11   (k11),
        .x00   (x00),
        .x10   (x10),
        .busy  (busy),
        .done  (done),
        .X00   (X00),
`ifdef KF_UPD_SAT_FLAG_EN
        .sat   (sat),
`endif
        .X10   (X10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int kk00, input int kk01, input int kk10, input int kk11,
                           input int xx00, input int xx10,
                           input int zz00, input int zz10, input int zzh00, input int zzh10);
        k00  = N'(kk00);
        k01  = N'(kk01);
        k10  = N'(kk10);
        k11  = N'(kk11);
        x00  = N'(xx00);
        x10  = N'(xx10);
        z00  = N'(zz00);
        z10  = N'(zz10);
        zh00 = N'(zzh00);
        zh10 = N'(zzh10);
    endtask

    // Pulse start so that it is sampled at the next rising edge (E0); returns 1 ns after E0.
    task automatic fire();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Bounded wait for done; reports edges counted after E0 (expected 5).
    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 5);
    endtask

    task automatic run_op(input string tag, input int e00, input int e10, input int esat);
        fire();
        wait_done(tag);
        chk({tag, "_X00"}, int'($signed(X00)), e00);
        chk({tag, "_X10"}, int'($signed(X10)), e10);
`ifdef KF_UPD_SAT_FLAG_EN
        chk({tag, "_sat"}, int'(sat), esat);
`endif
    endtask

    initial begin
        int ndone;
        int got00;
        int got10;

        rst_n = 1'b0;
        start = 1'b0;
        set_ops(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_X00", int'($signed(X00)), 0);
        chk("rst_X10", int'($signed(X10)), 0);
`ifdef KF_UPD_SAT_FLAG_EN
        chk("rst_sat", int'(sat), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // 1. K=0: X=x; busy through M0..WB, done exactly after the 6th edge.
        set_ops(0, 0, 0, 0, 1536, -768, 777, -55, 12, 9);
        fire();
        chk("t1_busy_M0", int'(busy), 1);
        chk("t1_done_M0", int'(done), 0);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            chk("t1_busy_run", int'(busy), 1);
            chk("t1_done_run", int'(done), 0);
        end
        @(posedge clk);
        #1;
        chk("t1_done", int'(done), 1);
        chk("t1_busy_at_done", int'(busy), 0);
        chk("t1_X00", int'($signed(X00)), 1536);
        chk("t1_X10", int'($signed(X10)), -768);
        @(posedge clk);
        #1;
        chk("t1_done_single", int'(done), 0);
        chk("t1_X00_hold", int'($signed(X00)), 1536);

        // 2. K=I, x=0, y=[1536,768]
        set_ops(1024, 0, 0, 1024, 0, 0, 2048, 1024, 512, 256);
        run_op("t2", 1536, 768, 0);

        // 3. K=diag(0.5,0.25), x=[1,1], z=[1,2]
        set_ops(512, 0, 0, 256, 1024, 1024, 1024, 2048, 0, 0);
        run_op("t3", 1536, 1536, 0);

        // 4. Rounding half up: 512/1024 -> 1, -512/1024 -> 0
        set_ops(1, 0, 0, 1, 0, 0, 512, -512, 0, 0);
        run_op("t4", 1, 0, 0);

        // 4b. Rounding just past half: -513/1024 -> -1, 513/1024 -> 1
        set_ops(1, 0, 0, 1, 0, 0, -513, 513, 0, 0);
        run_op("t4b", -1, 1, 0);

        // 4c. Off-diagonal terms: X00 = (512*1024 + 1024*(-1024))/1024 = -512
        set_ops(512, 1024, 256, 0, 0, 100, 1024, -1024, 0, 0);
        run_op("t4c", -512, 356, 0);

        // 5. Final clamp, positive and negative
        set_ops(1024, 0, 0, 1024, 500000, 0, 100000, 0, 0, 0);
        run_op("t5p", 524287, 0, 1);
        set_ops(1024, 0, 0, 1024, -500000, 0, -100000, 0, 0, 0);
        run_op("t5n", -524288, 0, 1);

        // 5b. Innovation clamp: 400000-(-400000) -> 524287, times 0.5 -> 262144
        set_ops(512, 0, 0, 0, 0, 0, 400000, 0, -400000, 0);
        run_op("t5y", 262144, 0, 1);

        // 5c. Clean operation clears the flag again
        set_ops(1024, 0, 0, 1024, 0, 0, 10, 20, 0, 0);
        run_op("t5c", 10, 20, 0);

        // 6a. start during M2 with new operands is ignored
        set_ops(0, 0, 0, 0, 100, 200, 0, 0, 0, 0);
        fire();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        set_ops(1024, 0, 0, 1024, 7, 9, 3000, 3000, 0, 0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        got00 = 0;
        got10 = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                ndone++;
                got00 = int'($signed(X00));
                got10 = int'($signed(X10));
            end
            @(posedge clk);
            #1;
        end
        chk("t6_done_count", ndone, 1);
        chk("t6_X00", got00, 100);
        chk("t6_X10", got10, 200);

        // 6b. Reset during M1 aborts; outputs cleared, no done
        set_ops(1024, 0, 0, 1024, 0, 0, 2048, 1024, 0, 0);
        fire();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("t6r_done", int'(done), 0);
        chk("t6r_busy", int'(busy), 0);
        chk("t6r_X00", int'($signed(X00)), 0);
        chk("t6r_X10", int'($signed(X10)), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
            end
        end
        chk("t6r_no_done", ndone, 0);

        // 6c. Fresh start after the abort completes normally
        run_op("t6n", 2048, 1024, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
